register_serializer: RTL and testbench

Parallel-to-serial reader for the processor's parallel load registers. It captures a DATA_WIDTH word on an active-low load strobe and shifts it out MSB-first, one bit per accepted valid/ready beat. It sits downstream of a register's data output and feeds bit-serial sinks such as a debug/trace port or a UART transmitter front end. It signals completion with a one-cycle done pulse.

---
 rtl/register_serializer_if.sv | 38 +++
 rtl/register_serializer.sv | 79 +++++++
 tb/tb_register_serializer.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/register_serializer_if.sv
// Load/data request and serial valid/ready stream of the
// register serializer.
interface register_serializer_if #(
   parameter int DATA_WIDTH = 16
) ();
   localparam int CW = $clog2(DATA_WIDTH + 1);

   logic                  ld_ni;
   logic [DATA_WIDTH-1:0] data_i;
   logic                  ready_i;
   logic                  serial_o;
   logic                  valid_o;
   logic                  busy_o;
   logic                  done_o;
   logic [CW-1:0]         bits_left_o;

   modport master (
      output ld_ni,
      output data_i,
      output ready_i,
      input  serial_o,
      input  valid_o,
      input  busy_o,
      input  done_o,
      input  bits_left_o
   );

   modport slave (
      input  ld_ni,
      input  data_i,
      input  ready_i,
      output serial_o,
      output valid_o,
      output busy_o,
      output done_o,
      output bits_left_o
   );
endinterface

// File: rtl/register_serializer.sv
// Captures a parallel word on an active-low strobe and shifts
// it out MSB-first, one bit per accepted valid/ready beat.
module register_serializer #(
   parameter int DATA_WIDTH = 16
) (
   input logic                   clk_i,
   input logic                   reset_ni,
   register_serializer_if.slave  bus
);
   localparam int CW = $clog2(DATA_WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t                state;
   logic [DATA_WIDTH-1:0] shreg;
   logic [CW-1:0]         cnt;
   logic                  valid_q;
   logic                  busy_q;
   logic                  done_q;

   // Everything moves on the falling edge of the clock.
   always_ff @(negedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state   <= IDLE;
         shreg   <= '0;
         cnt     <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (!bus.ld_ni) begin
                  shreg   <= bus.data_i;
                  cnt     <= CW'(DATA_WIDTH);
                  state   <= SHIFT;
                  valid_q <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            SHIFT: begin
               if (bus.ready_i) begin
                  shreg <= {shreg[DATA_WIDTH-2:0], 1'b0};
                  cnt   <= cnt - CW'(1);
                  if (cnt == CW'(1)) begin
                     state   <= DONE;
                     valid_q <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
            end
            DONE: begin
               state  <= IDLE;
               done_q <= 1'b0;
               busy_q <= 1'b0;
            end
            default: begin
               state   <= IDLE;
               shreg   <= '0;
               cnt     <= '0;
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   // Gate with valid so the line idles low regardless of shreg.
   assign bus.serial_o    = valid_q & shreg[DATA_WIDTH-1];
   assign bus.valid_o     = valid_q;
   assign bus.busy_o      = busy_q;
   assign bus.done_o      = done_q;
   assign bus.bits_left_o = cnt;
endmodule

// File: tb/tb_register_serializer.sv
// Randomized and directed bench for register_serializer, 16- and
// 8-bit instances against a queue-based reference model.
module tb_register_serializer;
   logic clk = 1'b0;
   logic reset_ni = 1'b1;

   always #5 clk = ~clk;

   register_serializer_if #(.DATA_WIDTH(16)) bus16 ();
   register_serializer_if #(.DATA_WIDTH(8))  bus8 ();

   register_serializer #(.DATA_WIDTH(16)) dut16 (
      .clk_i    (clk),
      .reset_ni (reset_ni),
      .bus      (bus16.slave)
   );

   register_serializer #(.DATA_WIDTH(8)) dut8 (
      .clk_i    (clk),
      .reset_ni (reset_ni),
      .bus      (bus8.slave)
   );

   logic        ld  [2];
   logic [15:0] dat [2];
   logic        rdy [2];
   logic        ser [2];
   logic        vld [2];
   logic        bsy [2];
   logic        dn  [2];
   logic [4:0]  bl  [2];

   assign bus16.ld_ni   = ld[0];
   assign bus16.data_i  = dat[0];
   assign bus16.ready_i = rdy[0];
   assign bus8.ld_ni    = ld[1];
   assign bus8.data_i   = dat[1][7:0];
   assign bus8.ready_i  = rdy[1];

   assign ser[0] = bus16.serial_o;
   assign vld[0] = bus16.valid_o;
   assign bsy[0] = bus16.busy_o;
   assign dn[0]  = bus16.done_o;
   assign bl[0]  = bus16.bits_left_o;
   assign ser[1] = bus8.serial_o;
   assign vld[1] = bus8.valid_o;
   assign bsy[1] = bus8.busy_o;
   assign dn[1]  = bus8.done_o;
   assign bl[1]  = 5'(bus8.bits_left_o);

   // Reference: a queue of bits still owed to the sink.
   bit          mq [2][$];
   bit          mdone [2];
   int          wid [2] = '{16, 8};
   int          edge_n = 0;
   int          cap_edge [2] = '{0, 0};
   int          done_edge [2] = '{0, 0};
   int          caps [2] = '{0, 0};
   logic [15:0] got [2] = '{16'h0, 16'h0};
   logic [15:0] word_done [2] = '{16'h0, 16'h0};

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic model_edge();
      for (int i = 0; i < 2; i++) begin
         if (!reset_ni) begin
            mq[i].delete();
            mdone[i] = 1'b0;
         end else if (mdone[i]) begin
            mdone[i] = 1'b0;
         end else if (mq[i].size() > 0) begin
            if (rdy[i]) begin
               void'(mq[i].pop_front());
               if (mq[i].size() == 0) begin
                  mdone[i] = 1'b1;
                  done_edge[i] = edge_n;
                  word_done[i] = got[i];
               end
            end
         end else if (!ld[i]) begin
            for (int b = wid[i] - 1; b >= 0; b--)
               mq[i].push_back(dat[i][b]);
            cap_edge[i] = edge_n;
            caps[i]++;
            got[i] = '0;
         end
      end
   endtask

   task automatic compare();
      for (int i = 0; i < 2; i++) begin
         logic ev;
         ev = (mq[i].size() > 0);
         chk($sformatf("valid%0d", i), vld[i], ev);
         chk($sformatf("serial%0d", i), ser[i],
             ev ? mq[i][0] : 1'b0);
         chk($sformatf("busy%0d", i), bsy[i], ev | mdone[i]);
         chk($sformatf("done%0d", i), dn[i], mdone[i]);
         chk($sformatf("bits_left%0d", i), bl[i], mq[i].size());
      end
   endtask

   task automatic step();
      for (int i = 0; i < 2; i++)
         if (reset_ni && vld[i] && rdy[i])
            got[i] = {got[i][14:0], ser[i]};
      @(negedge clk);
      edge_n++;
      model_edge();
      @(posedge clk);
      #1;
      compare();
   endtask

   task automatic load(input int i, input logic [15:0] d);
      ld[i] = 1'b0;
      dat[i] = d;
      step();
      ld[i] = 1'b1;
   endtask

   initial begin
      int c0;
      int e0;
      for (int i = 0; i < 2; i++) begin
         ld[i] = 1'b1;
         dat[i] = '0;
         rdy[i] = 1'b0;
      end
      #1 reset_ni = 1'b0;
      @(posedge clk);
      #1;
      compare();
      chk("rst_bits_left", bl[0], 0);
      step();
      step();
      reset_ni = 1'b1;
      step();

      // basic transfer
      rdy[0] = 1'b1;
      load(0, 16'hA5C3);
      repeat (17) step();
      chk("basic_lat", done_edge[0] - cap_edge[0], 16);
      chk("basic_word", word_done[0], 16'hA5C3);
      chk("basic_idle", bsy[0], 0);

      // asynchronous reset mid-shift
      load(0, 16'hA5C3);
      repeat (5) step();
      chk("mid_bits_left", bl[0], 11);
      #1 reset_ni = 1'b0;
      #1;
      chk("async_valid", vld[0], 0);
      chk("async_serial", ser[0], 0);
      chk("async_busy", bsy[0], 0);
      chk("async_done", dn[0], 0);
      chk("async_bits", bl[0], 0);
      for (int i = 0; i < 2; i++) begin
         mq[i].delete();
         mdone[i] = 1'b0;
      end
      step();
      reset_ni = 1'b1;
      step();
      step();
      chk("post_rst_bits", bl[0], 0);
      chk("post_rst_busy", bsy[0], 0);

      // backpressure
      rdy[0] = 1'b1;
      load(0, 16'h8001);
      step();
      rdy[0] = 1'b0;
      repeat (3) step();
      rdy[0] = 1'b1;
      for (int k = 0; k < 40 && bl[0] != 5'd1; k++)
         step();
      chk("bp_last", bl[0], 1);
      rdy[0] = 1'b0;
      repeat (2) step();
      chk("bp_hold", bl[0], 1);
      rdy[0] = 1'b1;
      step();
      chk("bp_lat", done_edge[0] - cap_edge[0], 21);
      step();
      chk("bp_word", word_done[0], 16'h8001);

      // load ignored while busy
      c0 = caps[0];
      load(0, 16'hFFFF);
      ld[0] = 1'b0;
      dat[0] = 16'h0000;
      repeat (17) step();
      ld[0] = 1'b1;
      repeat (2) step();
      chk("ign_caps", caps[0] - c0, 1);
      chk("ign_word", word_done[0], 16'hFFFF);
      chk("ign_busy", bsy[0], 0);

      // back-to-back words
      c0 = caps[0];
      ld[0] = 1'b0;
      dat[0] = 16'h1234;
      step();
      e0 = cap_edge[0];
      dat[0] = 16'hBEEF;
      repeat (17) step();
      chk("b2b_word0", word_done[0], 16'h1234);
      step();
      chk("b2b_gap", cap_edge[0] - e0, 18);
      ld[0] = 1'b1;
      repeat (17) step();
      chk("b2b_word1", word_done[0], 16'hBEEF);
      chk("b2b_caps", caps[0] - c0, 2);

      // 8-bit instance
      rdy[1] = 1'b1;
      load(1, 16'h0081);
      chk("w8_bits", bl[1], 8);
      repeat (9) step();
      chk("w8_lat", done_edge[1] - cap_edge[1], 8);
      chk("w8_word", word_done[1], 16'h0081);

      // randomized traffic on both instances
      repeat (400) begin
         for (int i = 0; i < 2; i++) begin
            ld[i] = ($urandom_range(0, 3) != 0);
            rdy[i] = ($urandom_range(0, 3) != 0);
            dat[i] = 16'($urandom);
         end
         step();
      end
      for (int i = 0; i < 2; i++) begin
         ld[i] = 1'b1;
         rdy[i] = 1'b1;
      end
      repeat (20) step();
      chk("rnd_idle16", bsy[0], 0);
      chk("rnd_idle8", bsy[1], 0);

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end
endmodule
